ac_register: RTL and testbench

- Accumulator datapath stage for the basic-computer model: the 16-bit AC register, its ALU and the E (carry/link) flip-flop.
- Sits directly downstream of the accumulator control logic and consumes its three strobes:
  - LD: load the ALU result.
  - INR: increment.
  - CLR: clear.
- Also consumes the one-hot operation selects decoded from the same instruction.
- Feeds AC, E and status flags back to the sequencer and the skip/branch logic.

---
 rtl/ac_register_if.sv | 60 ++++++
 rtl/ac_register.sv | 114 +++++++++++
 tb/tb_ac_register.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ac_register_if.sv
// ac_register_if
//   Bundles the accumulator stage's control strobes, one-hot op selects,
//   operands and results so the control logic and the AC datapath share
//   one connection.
//   Signals:
//     LD, INR, CLR         - strobes from the accumulator control logic
//     OP_AND .. OP_SHL     - one-hot ALU operation selects
//     DR, INPR             - data-register and input-register operands
//     AC, E                - registered accumulator and link bit
//     AC_ZERO, AC_NEG      - combinational status flags derived from AC
//     OP_ERR               - registered one-cycle illegal-select pulse
//     OVF                  - signed overflow flag (only with AC_OVF_FLAG_EN)
//   Modports:
//     master - the controller side (drives strobes/operands, reads results)
//     slave  - the accumulator register itself
interface ac_register_if #(
  parameter int WIDTH      = 16,
  parameter int INPR_WIDTH = 8
);
  logic                  LD;
  logic                  INR;
  logic                  CLR;
  logic                  OP_AND;
  logic                  OP_ADD;
  logic                  OP_DR;
  logic                  OP_INPR;
  logic                  OP_CMA;
  logic                  OP_SHR;
  logic                  OP_SHL;
  logic [WIDTH-1:0]      DR;
  logic [INPR_WIDTH-1:0] INPR;
  logic [WIDTH-1:0]      AC;
  logic                  E;
  logic                  AC_ZERO;
  logic                  AC_NEG;
  logic                  OP_ERR;
`ifdef AC_OVF_FLAG_EN
  logic                  OVF;
`endif

  modport master (
    output LD, INR, CLR,
    output OP_AND, OP_ADD, OP_DR, OP_INPR, OP_CMA, OP_SHR, OP_SHL,
    output DR, INPR,
`ifdef AC_OVF_FLAG_EN
    input  OVF,
`endif
    input  AC, E, AC_ZERO, AC_NEG, OP_ERR
  );

  modport slave (
    input  LD, INR, CLR,
    input  OP_AND, OP_ADD, OP_DR, OP_INPR, OP_CMA, OP_SHR, OP_SHL,
    input  DR, INPR,
`ifdef AC_OVF_FLAG_EN
    output OVF,
`endif
    output AC, E, AC_ZERO, AC_NEG, OP_ERR
  );
endinterface

// File: rtl/ac_register.sv
// ac_register
//   Accumulator datapath stage of the basic-computer model: the AC register,
//   its ALU and the E (carry/link) flip-flop.
//   Ports:
//     CLK    - system clock, all state changes on the rising edge
//     RST_N  - asynchronous active-low reset (AC=0, E=0, OP_ERR=0, OVF=0)
//     bus    - ac_register_if.slave carrying strobes, op selects, DR/INPR
//              operands and the AC/E/AC_ZERO/AC_NEG/OP_ERR results
//   Strobe priority each cycle is CLR > LD > INR. An LD whose op selects are
//   not exactly one-hot leaves AC/E untouched and raises OP_ERR for one cycle.
//   Optional feature: define AC_OVF_FLAG_EN to add the registered signed
//   overflow flag bus.OVF (set by ADD/INR overflow, cleared by CLR).
//   WIDTH must be at least 9 and INPR_WIDTH must be less than WIDTH.
module ac_register #(
  parameter int WIDTH      = 16,
  parameter int INPR_WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  ac_register_if.slave bus
);

  logic [WIDTH-1:0] ac_q, ac_d;
  logic             e_q, e_d;
  logic             op_err_q, op_err_d;
`ifdef AC_OVF_FLAG_EN
  logic             ovf_q, ovf_d;
`endif

  logic [6:0]       op_sel;
  logic             op_legal;
  logic [WIDTH:0]   add_sum;

  // Gather the selects so legality is a single one-hot test.
  assign op_sel   = {bus.OP_AND, bus.OP_ADD, bus.OP_DR, bus.OP_INPR,
                     bus.OP_CMA, bus.OP_SHR, bus.OP_SHL};
  assign op_legal = $onehot(op_sel);
  assign add_sum  = {1'b0, ac_q} + {1'b0, bus.DR};

  always_comb begin
    ac_d     = ac_q;
    e_d      = e_q;
    op_err_d = 1'b0;
`ifdef AC_OVF_FLAG_EN
    ovf_d    = ovf_q;
`endif
    if (bus.CLR) begin
      ac_d = '0;
`ifdef AC_OVF_FLAG_EN
      ovf_d = 1'b0;
`endif
    end else if (bus.LD) begin
      if (!op_legal) begin
        op_err_d = 1'b1;
      end else if (bus.OP_AND) begin
        ac_d = ac_q & bus.DR;
      end else if (bus.OP_ADD) begin
        ac_d = add_sum[WIDTH-1:0];
        e_d  = add_sum[WIDTH];
`ifdef AC_OVF_FLAG_EN
        // Signed overflow: like-signed operands producing an opposite sign.
        ovf_d = (ac_q[WIDTH-1] == bus.DR[WIDTH-1]) &&
                (add_sum[WIDTH-1] != ac_q[WIDTH-1]);
`endif
      end else if (bus.OP_DR) begin
        ac_d = bus.DR;
      end else if (bus.OP_INPR) begin
        ac_d[INPR_WIDTH-1:0] = bus.INPR;
      end else if (bus.OP_CMA) begin
        ac_d = ~ac_q;
      end else if (bus.OP_SHR) begin
        ac_d = {e_q, ac_q[WIDTH-1:1]};
        e_d  = ac_q[0];
      end else begin
        ac_d = {ac_q[WIDTH-2:0], e_q};
        e_d  = ac_q[WIDTH-1];
      end
    end else if (bus.INR) begin
      ac_d = ac_q + WIDTH'(1);
`ifdef AC_OVF_FLAG_EN
      // Only the largest positive value overflows on increment.
      ovf_d = (ac_q == {1'b0, {(WIDTH-1){1'b1}}});
`endif
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ac_q     <= '0;
      e_q      <= 1'b0;
      op_err_q <= 1'b0;
`ifdef AC_OVF_FLAG_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      ac_q     <= ac_d;
      e_q      <= e_d;
      op_err_q <= op_err_d;
`ifdef AC_OVF_FLAG_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.AC      = ac_q;
  assign bus.E       = e_q;
  assign bus.OP_ERR  = op_err_q;
  assign bus.AC_ZERO = (ac_q == '0);
  assign bus.AC_NEG  = ac_q[WIDTH-1];
`ifdef AC_OVF_FLAG_EN
  assign bus.OVF     = ovf_q;
`endif

endmodule

// File: tb/tb_ac_register.sv
// tb_ac_register
//   Directed self-checking bench for ac_register. Each step drives strobes
//   and operands, lets one rising edge pass and then checks the registered
//   results one time unit later. Expected values are hand-computed constants.
module tb_ac_register;

  localparam int W  = 16;
  localparam int IW = 8;

  // Op-select encodings in the order {AND, ADD, DR, INPR, CMA, SHR, SHL}.
  localparam logic [6:0] S_NONE = 7'b0000000;
  localparam logic [6:0] S_AND  = 7'b1000000;
  localparam logic [6:0] S_ADD  = 7'b0100000;
  localparam logic [6:0] S_DR   = 7'b0010000;
  localparam logic [6:0] S_INPR = 7'b0001000;
  localparam logic [6:0] S_CMA  = 7'b0000100;
  localparam logic [6:0] S_SHR  = 7'b0000010;
  localparam logic [6:0] S_SHL  = 7'b0000001;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  ac_register_if #(.WIDTH(W), .INPR_WIDTH(IW)) bus ();

  ac_register #(.WIDTH(W), .INPR_WIDTH(IW)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's worth of inputs, then sample 1 unit after the edge.
  task automatic applyStimulus(input logic ld, input logic inr, input logic clr,
                               input logic [6:0] sel, input logic [W-1:0] dr,
                               input logic [IW-1:0] inpr);
    bus.LD      = ld;
    bus.INR     = inr;
    bus.CLR     = clr;
    bus.OP_AND  = sel[6];
    bus.OP_ADD  = sel[5];
    bus.OP_DR   = sel[4];
    bus.OP_INPR = sel[3];
    bus.OP_CMA  = sel[2];
    bus.OP_SHR  = sel[1];
    bus.OP_SHL  = sel[0];
    bus.DR      = dr;
    bus.INPR    = inpr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;

    // Reset held while a load is requested: state must stay cleared.
    applyStimulus(1'b1, 1'b0, 1'b0, S_DR, 16'hFFFF, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, S_DR, 16'hFFFF, 8'h00);
    checkOutput("rst_ac", 32'(bus.AC), 32'h0000);
    checkOutput("rst_e", 32'(bus.E), 32'h0);
    checkOutput("rst_zero", 32'(bus.AC_ZERO), 32'h1);
    checkOutput("rst_neg", 32'(bus.AC_NEG), 32'h0);
    checkOutput("rst_err", 32'(bus.OP_ERR), 32'h0);
`ifdef AC_OVF_FLAG_EN
    checkOutput("rst_ovf", 32'(bus.OVF), 32'h0);
`endif

    // Release away from the edge; the pending load lands on the next edge.
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, S_DR, 16'hFFFF, 8'h00);
    checkOutput("load_ac", 32'(bus.AC), 32'hFFFF);
    checkOutput("load_neg", 32'(bus.AC_NEG), 32'h1);
    checkOutput("load_zero", 32'(bus.AC_ZERO), 32'h0);

    // FFFF + 0002 carries out into E.
    applyStimulus(1'b1, 1'b0, 1'b0, S_ADD, 16'h0002, 8'h00);
    checkOutput("add_ac", 32'(bus.AC), 32'h0001);
    checkOutput("add_e", 32'(bus.E), 32'h1);
    checkOutput("add_err", 32'(bus.OP_ERR), 32'h0);
`ifdef AC_OVF_FLAG_EN
    checkOutput("add_ovf", 32'(bus.OVF), 32'h0);
`endif

    // Set up AC=8001, E=0: transfer 0, then add 8001 with no carry.
    applyStimulus(1'b1, 1'b0, 1'b0, S_DR, 16'h0000, 8'h00);
    checkOutput("dr_keeps_e", 32'(bus.E), 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, S_ADD, 16'h8001, 8'h00);
    checkOutput("add2_ac", 32'(bus.AC), 32'h8001);
    checkOutput("add2_e", 32'(bus.E), 32'h0);

    // Shift round trip through E.
    applyStimulus(1'b1, 1'b0, 1'b0, S_SHL, 16'h0000, 8'h00);
    checkOutput("shl_ac", 32'(bus.AC), 32'h0002);
    checkOutput("shl_e", 32'(bus.E), 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, S_SHR, 16'h0000, 8'h00);
    checkOutput("shr_ac", 32'(bus.AC), 32'h8001);
    checkOutput("shr_e", 32'(bus.E), 32'h0);

    // INPR replaces the low byte only, then complement.
    applyStimulus(1'b1, 1'b0, 1'b0, S_DR, 16'h1234, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, S_INPR, 16'h0000, 8'hAB);
    checkOutput("inpr_ac", 32'(bus.AC), 32'h12AB);
    applyStimulus(1'b1, 1'b0, 1'b0, S_CMA, 16'h0000, 8'h00);
    checkOutput("cma_ac", 32'(bus.AC), 32'hED54);
    checkOutput("cma_neg", 32'(bus.AC_NEG), 32'h1);

    // AND against a mask.
    applyStimulus(1'b1, 1'b0, 1'b0, S_DR, 16'h5555, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, S_AND, 16'h0F0F, 8'h00);
    checkOutput("and_ac", 32'(bus.AC), 32'h0505);

    // No strobe: hold.
    applyStimulus(1'b0, 1'b0, 1'b0, S_ADD, 16'hFFFF, 8'hFF);
    checkOutput("hold_ac", 32'(bus.AC), 32'h0505);

    // Make E=1 with FFFF + FFFF = 1_FFFE, then increment through the wrap.
    applyStimulus(1'b1, 1'b0, 1'b0, S_DR, 16'hFFFF, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, S_ADD, 16'hFFFF, 8'h00);
    checkOutput("add3_ac", 32'(bus.AC), 32'hFFFE);
    checkOutput("add3_e", 32'(bus.E), 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, S_NONE, 16'h0000, 8'h00);
    checkOutput("inr_ac", 32'(bus.AC), 32'hFFFF);
    applyStimulus(1'b0, 1'b1, 1'b0, S_NONE, 16'h0000, 8'h00);
    checkOutput("wrap_ac", 32'(bus.AC), 32'h0000);
    checkOutput("wrap_zero", 32'(bus.AC_ZERO), 32'h1);
    checkOutput("wrap_e", 32'(bus.E), 32'h1);

    // LD beats INR.
    applyStimulus(1'b1, 1'b1, 1'b0, S_DR, 16'h00FF, 8'h00);
    checkOutput("ld_over_inr", 32'(bus.AC), 32'h00FF);

    // CLR beats LD and INR; E untouched.
    applyStimulus(1'b1, 1'b1, 1'b1, S_DR, 16'h1234, 8'h00);
    checkOutput("clr_ac", 32'(bus.AC), 32'h0000);
    checkOutput("clr_e", 32'(bus.E), 32'h1);

    // Signed-overflow boundary on increment.
    applyStimulus(1'b1, 1'b0, 1'b0, S_DR, 16'h7FFF, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, S_NONE, 16'h0000, 8'h00);
    checkOutput("inr_ovf_ac", 32'(bus.AC), 32'h8000);
`ifdef AC_OVF_FLAG_EN
    checkOutput("inr_ovf", 32'(bus.OVF), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, S_NONE, 16'h0000, 8'h00);
    checkOutput("clr_ovf", 32'(bus.OVF), 32'h0);
`endif

    // Illegal selects: two high, then none high.
    applyStimulus(1'b1, 1'b0, 1'b0, S_DR, 16'h5555, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, S_AND | S_ADD, 16'hFFFF, 8'h00);
    checkOutput("ill2_ac", 32'(bus.AC), 32'h5555);
    checkOutput("ill2_e", 32'(bus.E), 32'h1);
    checkOutput("ill2_err", 32'(bus.OP_ERR), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, S_NONE, 16'h0000, 8'h00);
    checkOutput("ill2_err_drop", 32'(bus.OP_ERR), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, S_NONE, 16'hFFFF, 8'h00);
    checkOutput("ill0_ac", 32'(bus.AC), 32'h5555);
    checkOutput("ill0_e", 32'(bus.E), 32'h1);
    checkOutput("ill0_err", 32'(bus.OP_ERR), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, S_NONE, 16'h0000, 8'h00);
    checkOutput("ill0_err_drop", 32'(bus.OP_ERR), 32'h0);

    // Mid-cycle reset clears state without waiting for an edge.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_ac", 32'(bus.AC), 32'h0000);
    checkOutput("async_rst_e", 32'(bus.E), 32'h0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, S_NONE, 16'h0000, 8'h00);
    checkOutput("post_rst_inr", 32'(bus.AC), 32'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
